// File: rtl/hsv_core_fetch_stream_if.sv
// hsv_core_fetch_stream_if: fetch_data_t record and the read-only imem AXI bus (axib_if)
// axib_if.m drives AR/R-ready plus the tied-off AW/W/B requests; axib_if.s is the memory side.
package hsv_core_fetch_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
    logic [31:0] pc_increment;
  } fetch_data_t;
endpackage

interface axib_if;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  modport m (
    output araddr, arlen, arsize, arburst, arid, arvalid, rready,
           awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );
  modport s (
    input  araddr, arlen, arsize, arburst, arid, arvalid, rready,
           awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rresp, rlast, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/hsv_core_fetch_stream.sv
// hsv_core_fetch_stream: instruction prefetcher issuing aligned INCR bursts on imem and streaming beats to decode
// Ports: clk_core/rst_core clock and sync active-high reset; flush_req/flush_target/flush_ack redirect;
// fetch_data/valid_o/ready_i decode stream; imem AXI read master (write channels tied off).
module hsv_core_fetch_stream
  import hsv_core_fetch_pkg::*;
#(
  parameter int          BURST_LEN  = 4,
  parameter int          MAX_BURSTS = 2,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic [31:0] flush_target,
  input  logic        flush_req,
  output logic        flush_ack,
  output fetch_data_t fetch_data,
  output logic        valid_o,
  input  logic        ready_i,
  axib_if.m           imem
);
  localparam int LG = $clog2(BURST_LEN);
  localparam int CW = $clog2(MAX_BURSTS + 1);
  localparam int SW = CW + 1;
  typedef enum logic [1:0] {RUN, HOLD, FLUSH} state_t;
  state_t state;
  logic [CW-1:0] live, stale;
  logic [31:0] pc, burst_base, tgt, next_base;
  logic hold, ar_acc, ar_stuck, beat_stale, r_hs, stale_end, live_end, live_hs;
  logic unused;
  assign tgt = {flush_target[31:2], 2'b00};
  assign hold = state == HOLD;
  assign imem.arvalid = hold | (state == RUN && SW'(live) + SW'(stale) < SW'(MAX_BURSTS));
  assign imem.araddr = burst_base;
  // shortened first burst after a redirect so the next one starts on a BURST_LEN boundary
  assign imem.arlen = 8'(BURST_LEN - 1) - 8'(burst_base[LG+1:2]);
  assign imem.arsize = 3'd2;
  assign imem.arburst = 2'b01;
  assign imem.arid = '0;
  assign imem.awaddr = '0;
  assign imem.awvalid = 1'b0;
  assign imem.wdata = '0;
  assign imem.wstrb = '0;
  assign imem.wlast = 1'b0;
  assign imem.wvalid = 1'b0;
  assign imem.bready = 1'b0;
  assign ar_acc = imem.arvalid & imem.arready;
  assign ar_stuck = imem.arvalid & ~imem.arready;
  // responses return in order, so anything owed to pre-flush bursts arrives first
  assign beat_stale = stale != '0 | flush_req;
  assign imem.rready = beat_stale | ready_i;
  assign valid_o = imem.rvalid & ~beat_stale;
  assign r_hs = imem.rvalid & imem.rready;
  assign stale_end = r_hs & imem.rlast & beat_stale;
  assign live_end = r_hs & imem.rlast & ~beat_stale;
  assign live_hs = r_hs & ~beat_stale;
  assign next_base = (burst_base | 32'(BURST_LEN * 4 - 1)) + 32'd1;
  assign fetch_data = '{pc: pc, insn: imem.rdata, fault: imem.rresp[1], pc_increment: pc + 32'd4};
  assign flush_ack = state == FLUSH;
  assign unused = ^{flush_target[1:0], imem.rresp[0], imem.awready, imem.wready, imem.bvalid, imem.bresp};
  // while an AR is stuck in HOLD its address must not move, so the redirect target parks in pc
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state <= FLUSH;
      live <= '0;
      stale <= '0;
      pc <= RESET_PC;
      burst_base <= RESET_PC;
    end else begin
      state <= state == RUN ? (flush_req ? (ar_stuck ? HOLD : FLUSH) : RUN) :
               hold ? (imem.arready ? FLUSH : HOLD) : (flush_req ? FLUSH : RUN);
      stale <= stale + (flush_req ? live : '0) + CW'(ar_acc & (flush_req | hold)) - CW'(stale_end);
      live <= flush_req ? '0 : live + CW'(ar_acc & ~hold) - CW'(live_end);
      pc <= flush_req ? tgt : live_hs ? pc + 32'd4 : pc;
      burst_base <= ar_stuck && (flush_req || hold) ? burst_base :
                    flush_req ? tgt : hold ? pc : ar_acc ? next_base : burst_base;
    end
  end
endmodule

// File: tb/tb_hsv_core_fetch_stream.sv
// tb_hsv_core_fetch_stream: randomized AXI slave plus scoreboard of the expected instruction stream
module tb_hsv_core_fetch_stream;
  import hsv_core_fetch_pkg::*;
  localparam int BL = 4;
  localparam int MB = 2;
  logic clk_core = 1'b0;
  logic rst_core = 1'b1;
  logic [31:0] flush_target = '0;
  logic flush_req = 1'b0;
  logic ready_i = 1'b0;
  logic flush_ack, valid_o;
  fetch_data_t fetch_data;
  axib_if imem();
  hsv_core_fetch_stream #(.BURST_LEN(BL), .MAX_BURSTS(MB), .RESET_PC(32'h0)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_target(flush_target), .flush_req(flush_req),
    .flush_ack(flush_ack), .fetch_data(fetch_data), .valid_o(valid_o), .ready_i(ready_i), .imem(imem)
  );
  always #5 clk_core = ~clk_core;
  typedef struct {logic [31:0] pc; logic [31:0] insn; logic fault;} exp_t;
  typedef struct {logic [31:0] addr; int left;} burst_t;
  exp_t exp_q[$];
  burst_t ar_q[$];
  int tests = 0, fails = 0, delivered = 0;
  int p_arready = 100, p_rvalid = 100, p_ready = 100;
  logic [31:0] exp_ar = '0, ar_prev_addr = '0;
  logic [7:0] ar_prev_len = '0;
  logic ar_pend = 1'b0, acked = 1'b0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic err_at(input logic [31:0] a);
    return ((a >> 2) % 5) == 1;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_seg(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back('{a, mem(a), err_at(a)});
    end
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_core);
      if (!rst_core) begin
        if (flush_req && imem.rvalid) chk("valid_during_flush", 32'(valid_o), 0);
        if (valid_o && ready_i) begin
          chk("beat_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("pc", fetch_data.pc, e.pc);
            chk("insn", fetch_data.insn, e.insn);
            chk("fault", 32'(fetch_data.fault), 32'(e.fault));
            chk("pc_increment", fetch_data.pc_increment, e.pc + 32'd4);
            delivered++;
          end
        end
      end
    end
  end
  task automatic cycle();
    logic r_done;
    @(negedge clk_core);
    if (ar_pend) begin
      chk("arvalid_hold", 32'(imem.arvalid), 1);
      chk("araddr_hold", imem.araddr, ar_prev_addr);
      chk("arlen_hold", 32'(imem.arlen), 32'(ar_prev_len));
    end
    if (imem.arvalid) chk("arlen", 32'(imem.arlen), 32'(BL - 1 - int'((imem.araddr >> 2) % BL)));
    if (imem.arvalid && imem.arready) begin
      chk("outstanding", 32'(ar_q.size() < MB), 1);
      chk("ar_fixed", {imem.arid, imem.arsize, imem.arburst, imem.awvalid, imem.wvalid, imem.bready}, 32'b0000_010_01_000);
      if (!flush_req) begin
        chk("araddr", imem.araddr, exp_ar);
        exp_ar = exp_ar + 32'(4 * (BL - int'((exp_ar >> 2) % BL)));
      end
      ar_q.push_back('{imem.araddr, int'(imem.arlen) + 1});
    end
    ar_pend = imem.arvalid && !imem.arready;
    ar_prev_addr = imem.araddr;
    ar_prev_len = imem.arlen;
    r_done = imem.rvalid && imem.rready;
    if (r_done) begin
      ar_q[0].left--;
      ar_q[0].addr += 4;
      if (ar_q[0].left == 0) void'(ar_q.pop_front());
    end
    if (flush_req && flush_ack) acked = 1'b1;
    @(posedge clk_core);
    #1;
    imem.arready = $urandom_range(0, 99) < p_arready;
    if (!imem.rvalid || r_done) begin
      imem.rvalid = ar_q.size() > 0 && $urandom_range(0, 99) < p_rvalid;
      if (imem.rvalid) begin
        imem.rdata = mem(ar_q[0].addr);
        imem.rresp = err_at(ar_q[0].addr) ? 2'b10 : 2'b00;
        imem.rlast = ar_q[0].left == 1;
      end
    end
    ready_i = $urandom_range(0, 99) < p_ready;
  endtask
  task automatic do_flush(input logic [31:0] t, input int min_cycles, input bit jitter);
    int n;
    n = 0;
    acked = 1'b0;
    flush_req = 1'b1;
    flush_target = t;
    exp_q.delete();
    while ((!acked || n < min_cycles) && n < 300) begin
      if (jitter && $urandom_range(0, 3) == 0) flush_target = $urandom;
      if (n == 3 && p_arready == 0) p_arready = 100;
      cycle();
      n++;
    end
    chk("flush_ack_seen", 32'(acked), 1);
    flush_req = 1'b0;
    push_seg({flush_target[31:2], 2'b00});
    exp_ar = {flush_target[31:2], 2'b00};
  endtask
  initial begin
    imem.arready = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;
    imem.rresp = '0;
    imem.rlast = 1'b0;
    imem.awready = 1'b0;
    imem.wready = 1'b0;
    imem.bvalid = 1'b0;
    imem.bresp = '0;
    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    chk("reset_flush_ack", 32'(flush_ack), 1);
    chk("reset_valid_o", 32'(valid_o), 0);
    chk("reset_arvalid", 32'(imem.arvalid), 0);
    @(posedge clk_core);
    #1;
    rst_core = 1'b0;
    push_seg(32'h0);
    exp_ar = 32'h0;
    repeat (40) cycle();
    do_flush(32'h0000_1008, 2, 1'b0);
    repeat (40) cycle();
    p_rvalid = 0;
    repeat (20) cycle();
    chk("stall_outstanding", 32'(ar_q.size()), 32'(MB));
    do_flush(32'h0000_2000, 3, 1'b0);
    p_rvalid = 100;
    repeat (40) cycle();
    p_arready = 0;
    repeat (20) cycle();
    chk("ar_stuck_before_flush", 32'(imem.arvalid), 1);
    do_flush(32'h0000_3004, 2, 1'b0);
    repeat (40) cycle();
    for (int s = 0; s < 30; s++) begin
      p_arready = $urandom_range(20, 100);
      p_rvalid = $urandom_range(30, 100);
      p_ready = $urandom_range(30, 100);
      repeat ($urandom_range(10, 150)) cycle();
      if ($urandom_range(0, 3) == 0) p_arready = 0;
      do_flush($urandom, $urandom_range(1, 4), 1'b1);
    end
    p_arready = 100;
    p_rvalid = 100;
    p_ready = 100;
    repeat (60) cycle();
    chk("delivered_total", 32'(delivered > 200), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
